instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage that produces the 32-bit `Instruction` word consumed by the decode-stage controller. It owns the program counter and issues single-outstanding requests to instruction memory. It holds each returned word in an IF/ID output register until decode accepts it, and applies branch, jump and JR redirects coming back from decode, including flushing any in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0.

Ports (one clock; reset is asynchronous and active-low):
- `Clk`, input, 1, rising-edge clock.
- `Rst`, input, 1, asynchronous active-low reset.
- `ImemReq`, output, 1, one-cycle fetch request strobe.
- `ImemAddr`, output, 32, word address for the request; equals PC.
- `ImemValid`, input, 1, response strobe; at most one per request, earliest 1 cycle after `ImemReq`.
- `ImemData`, input, 32, instruction word, qualified by `ImemValid`.
- `Stall`, input, 1, decode cannot accept the held instruction this cycle.
- `BranchTaken`, input, 1, taken branch resolved in decode.
- `BranchTarget`, input, 32, branch target address.
- `JumpEn`, input, 1, J/JAL in decode.
- `JumpIndex`, input, 26, instruction bits [25:0] of the jump.
- `JREn`, input, 1, JR in decode.
- `JRTarget`, input, 32, rs value for JR.
- `Instruction`, output, 32, IF/ID instruction to the controller.
- `PCPlus4`, output, 32, address of `Instruction` + 4.
- `InstrValid`, output, 1, `Instruction` is a real fetched word.

## Operation
- `Redirect` = `JREn | JumpEn | BranchTaken`.
- Target priority is JR, then Jump, then Branch:
  - JR: `JRTarget`.
  - Jump: {`PCPlus4`[31:28], `JumpIndex`, 2'b00}.
  - Branch: `BranchTarget`.
- Target bits [1:0] are forced to 0.
- Consume happens when `InstrValid & ~Stall`.
- States:
  - FETCH:
    - `ImemReq` = ~`Redirect` & (~`InstrValid` | ~`Stall`); when asserted, go to WAIT.
    - On `Redirect`: PC <= target, stay in FETCH, no request.
  - WAIT:
    - `ImemValid` with Drop=0 and no `Redirect`: load `Instruction`<=`ImemData`, `PCPlus4`<=PC+4, `InstrValid`<=1, PC<=PC+4, go to FETCH.
    - `ImemValid` with Drop=1 or `Redirect`: discard the word, clear Drop, go to FETCH.
    - `Redirect` without `ImemValid`: set Drop, stay in WAIT.
- Any `Redirect` updates PC to the target and clears `InstrValid` on the next edge (flush), regardless of `Stall`.
- Consume without a new load: `InstrValid` <= 0.
- Consume and load in the same cycle: the new word replaces the old one.
- Loading can only happen while the register is empty or being consumed; the FETCH request gate guarantees this.
- PC+4 wraps modulo 2^32.
- `ImemValid` outside WAIT is ignored.
- A second `Redirect` while Drop=1 only updates PC.

## Timing
- Reset values:
  - PC = `RESET_PC`, state = FETCH, Drop = 0.
  - `Instruction` = 32'h0 (NOP), `PCPlus4` = 0, `InstrValid` = 0.
  - `ImemReq` = 0 while `Rst` is low.
- The first request is issued in the first cycle after reset deasserts, with `ImemAddr` = `RESET_PC`.
- Latency: request in cycle N, response in N+k (k≥1), `InstrValid` high in N+k+1.
- Throughput with k=1 and no stall: one instruction every 2 cycles.
- `ImemReq` and `ImemAddr` are combinational from state, PC and inputs.
- All other outputs are registered.
- Reset asserted mid-fetch returns every register to its reset value immediately. Any later response from the aborted request is ignored, because the state is FETCH.

## Structure
- Shared package holds:
  - `RESET_PC` default.
  - NOP constant 32'h0000_0000.
  - FSM state encoding (FETCH, WAIT).
  - Opcode/funct constants: J 6'b000010, JAL 6'b000011, R-type funct JR 6'b001000.
- One sub-module, `pc_next_select`, is combinational. It takes the redirect inputs, `PCPlus4` and PC, and outputs the next PC with the priority and alignment rules above.
- The FSM and IF/ID registers stay in `instruction_fetch`.

## Test plan
- Reset, then release with `RESET_PC`=0 and 1-cycle memory:
  - `ImemReq` at cycle 1 with addr 0x0.
  - `InstrValid` at cycle 3 with `PCPlus4`=0x4.
  - Next request at addr 0x4.
- `Stall`=1 for 3 cycles while `InstrValid`=1:
  - `Instruction` and `PCPlus4` held constant.
  - No `ImemReq`.
  - Request resumes in the cycle `Stall` drops.
- `BranchTaken` with target 0x40 while in WAIT, response 2 cycles later:
  - Returned word discarded.
  - `InstrValid` cleared.
  - Next `ImemReq` at addr 0x40.
- `JumpEn` with `JumpIndex`=26'h0000010 and `PCPlus4`=0x1000_0008:
  - Next fetch addr 0x1000_0040.
- `JREn` and `BranchTaken` in the same cycle, `JRTarget`=0x123, `BranchTarget`=0x80:
  - Next fetch addr 0x120 (JR wins, low bits cleared).
- `Rst` pulsed low while in WAIT at PC 0x20:
  - Outputs return to reset values.
  - The late `ImemValid` is ignored.
  - First post-reset request is at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants, state encoding and address helpers for the instruction-fetch stage.
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_JAL  = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_WAIT  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // J/JAL keep the upper nibble of the delay-slot-free PC+4 of the jump itself.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_next_select.sv
// Redirect target selection: JR over Jump over Branch, word aligned.
module pc_next_select
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic        redirect,
  output logic [31:0] next_pc
);

  logic [31:0] raw_target_s;

  // Priority mux over the three redirect sources; hold PC when none is active.
  always_comb begin
    raw_target_s = pc;
    if (jr_en) begin
      raw_target_s = jr_target;
    end else if (jump_en) begin
      raw_target_s = jump_target(pc_plus4, jump_index);
    end else if (branch_taken) begin
      raw_target_s = branch_target;
    end else begin
      raw_target_s = pc;
    end
  end

  assign redirect = jr_en | jump_en | branch_taken;
  assign next_pc  = align_word(raw_target_s);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, IF/ID register and redirect flush.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemValid,
  input  logic [31:0] ImemData,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpEn,
  input  logic [25:0] JumpIndex,
  input  logic        JREn,
  input  logic [31:0] JRTarget,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4,
  output logic        InstrValid
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic         drop_r;
  logic [31:0]  instr_r;
  logic [31:0]  pc_plus4_r;
  logic         instr_valid_r;

  logic         redirect_s;
  logic [31:0]  target_s;
  logic         consume_s;
  logic         req_s;
  logic         load_s;

  pc_next_select u_pc_next_select (
    .pc            (pc_r),
    .pc_plus4      (pc_plus4_r),
    .branch_taken  (BranchTaken),
    .branch_target (BranchTarget),
    .jump_en       (JumpEn),
    .jump_index    (JumpIndex),
    .jr_en         (JREn),
    .jr_target     (JRTarget),
    .redirect      (redirect_s),
    .next_pc       (target_s)
  );

  // Request gate and IF/ID load qualification; a request only goes out when the register will be free.
  always_comb begin
    consume_s = instr_valid_r & ~Stall;
    req_s     = 1'b0;
    load_s    = 1'b0;
    if (!Rst) begin
      req_s = 1'b0;
    end else if (state_r == ST_FETCH) begin
      req_s = ~redirect_s & (~instr_valid_r | ~Stall);
    end else begin
      req_s = 1'b0;
    end
    if (state_r == ST_WAIT) begin
      load_s = ImemValid & ~drop_r & ~redirect_s;
    end else begin
      load_s = 1'b0;
    end
  end

  // Fetch FSM, PC and IF/ID register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r       <= ST_FETCH;
      pc_r          <= RESET_PC;
      drop_r        <= 1'b0;
      instr_r       <= NOP;
      pc_plus4_r    <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (redirect_s) begin
            pc_r <= target_s;
          end else if (req_s) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (ImemValid) begin
            state_r <= ST_FETCH;
            drop_r  <= 1'b0;
            if (redirect_s) begin
              pc_r <= target_s;
            end else if (!drop_r) begin
              pc_r <= pc_r + 32'd4;
            end else begin
              pc_r <= pc_r;
            end
          end else if (redirect_s) begin
            // The in-flight word belongs to the old path; remember to throw it away.
            drop_r <= 1'b1;
            pc_r   <= target_s;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_FETCH;
          drop_r  <= 1'b0;
        end
      endcase

      if (redirect_s) begin
        instr_valid_r <= 1'b0;
      end else if (load_s) begin
        instr_r       <= ImemData;
        pc_plus4_r    <= pc_r + 32'd4;
        instr_valid_r <= 1'b1;
      end else if (consume_s) begin
        instr_valid_r <= 1'b0;
      end else begin
        instr_valid_r <= instr_valid_r;
      end
    end
  end

  assign ImemReq     = req_s;
  assign ImemAddr    = pc_r;
  assign Instruction = instr_r;
  assign PCPlus4     = pc_plus4_r;
  assign InstrValid  = instr_valid_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a transaction-level model and a latency-programmable memory.
module tb_instruction_fetch;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemValid = 1'b0;
  logic [31:0] ImemData = 32'h0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        JumpEn = 1'b0;
  logic [25:0] JumpIndex = 26'h0;
  logic        JREn = 1'b0;
  logic [31:0] JRTarget = 32'h0;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic        InstrValid;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Rst(Rst), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemValid(ImemValid), .ImemData(ImemData), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .JumpEn(JumpEn), .JumpIndex(JumpIndex), .JREn(JREn), .JRTarget(JRTarget),
    .Instruction(Instruction), .PCPlus4(PCPlus4), .InstrValid(InstrValid)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int lat = 1;
  int found = 0;

  // memory: pending responses (due cycle, address)
  int          due_q[$];
  logic [31:0] adr_q[$];

  // model: what fetch owes the decoder, kept as a transaction view
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid, m_busy, m_dead, m_req;
  logic        s_req;
  logic [31:0] s_addr;

  logic [23:0] stall_pat = 24'b0110_0011_1000_1101_0010_0111;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hDEAD_BEEF ^ a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0;
    m_valid = 1'b0; m_busy = 1'b0; m_dead = 1'b0; m_req = 1'b0;
  endtask

  // first half of a cycle: drive memory, then compare at the falling edge
  task automatic half();
    ImemValid = 1'b0;
    ImemData  = 32'h0;
    if (due_q.size() > 0 && due_q[0] == cyc_n) begin
      ImemValid = 1'b1;
      ImemData  = mem_word(adr_q[0]);
      void'(due_q.pop_front());
      void'(adr_q.pop_front());
    end
    if (!Rst) model_reset();
    @(negedge Clk);
    m_req = Rst && !m_busy && !(JREn || JumpEn || BranchTaken) && (!m_valid || !Stall);
    check("imem_req", ImemReq, m_req);
    if (m_req) check("imem_addr", ImemAddr, m_pc);
    check("instr_valid", InstrValid, m_valid);
    if (m_valid) begin
      check("instruction", Instruction, m_instr);
      check("pc_plus4", PCPlus4, m_pc4);
    end
    s_req  = ImemReq;
    s_addr = ImemAddr;
  endtask

  // second half: advance the model on the rising edge, memory latches any request
  task automatic tick();
    logic        redir, accepted, load;
    logic [31:0] tgt;
    @(posedge Clk);
    if (!Rst) begin
      model_reset();
    end else begin
      redir = JREn || JumpEn || BranchTaken;
      if (JREn)        tgt = JRTarget;
      else if (JumpEn) tgt = {m_pc4[31:28], JumpIndex, 2'b00};
      else             tgt = BranchTarget;
      tgt[1:0] = 2'b00;
      accepted = m_busy && ImemValid;
      load = accepted && !m_dead && !redir;
      if (accepted) begin m_busy = 1'b0; m_dead = 1'b0; end
      else if (redir && m_busy) m_dead = 1'b1;
      if (m_req) m_busy = 1'b1;
      if (redir) begin
        m_pc = tgt; m_valid = 1'b0;
      end else if (load) begin
        m_instr = ImemData; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
      end else if (m_valid && !Stall) begin
        m_valid = 1'b0;
      end
      if (s_req) begin
        due_q.push_back(cyc_n + lat);
        adr_q.push_back(s_addr);
      end
    end
    cyc_n++;
    #1;
  endtask

  task automatic clear_redirect();
    BranchTaken = 1'b0; JumpEn = 1'b0; JREn = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge Clk); #1;
    half();
    check("rst_req", ImemReq, 32'd0);
    check("rst_valid", InstrValid, 32'd0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_pc4", PCPlus4, 32'h0);
    tick();

    Rst = 1'b1; lat = 1;
    half(); check("c1_req", ImemReq, 32'd1); check("c1_addr", ImemAddr, 32'h0); tick();
    half(); tick();
    half();
    check("c3_valid", InstrValid, 32'd1); check("c3_pc4", PCPlus4, 32'h4);
    check("c3_instr", Instruction, 32'hDEAD_BEEF); check("c3_addr", ImemAddr, 32'h4);
    tick();
    half(); tick();

    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      half();
      check("stall_instr", Instruction, 32'hDEAD_BEEB); check("stall_pc4", PCPlus4, 32'h8);
      check("stall_req", ImemReq, 32'd0);
      tick();
    end
    Stall = 1'b0;
    half(); check("resume_req", ImemReq, 32'd1); check("resume_addr", ImemAddr, 32'h8);
    lat = 3; tick();

    BranchTaken = 1'b1; BranchTarget = 32'h40;
    half(); tick(); clear_redirect();
    half(); tick();
    half(); check("drop_valid", InstrValid, 32'd0); tick();
    lat = 1;
    half(); check("br_req", ImemReq, 32'd1); check("br_addr", ImemAddr, 32'h40); tick();
    half(); tick();

    Stall = 1'b1; JREn = 1'b1; JRTarget = 32'h1000_0004;
    half(); check("br_instr", Instruction, 32'hDEAD_BEAF); check("br_pc4", PCPlus4, 32'h44);
    tick(); clear_redirect(); Stall = 1'b0;
    half(); check("flush_valid", InstrValid, 32'd0); check("jr_addr", ImemAddr, 32'h1000_0004); tick();
    half(); tick();

    JumpEn = 1'b1; JumpIndex = 26'h0000010;
    half(); check("j_pc4", PCPlus4, 32'h1000_0008); tick(); clear_redirect();
    half(); check("j_req", ImemReq, 32'd1); check("j_addr", ImemAddr, 32'h1000_0040); tick();
    half(); tick();

    JREn = 1'b1; JRTarget = 32'h123; BranchTaken = 1'b1; BranchTarget = 32'h80;
    half(); tick(); clear_redirect();
    half(); check("jrpri_addr", ImemAddr, 32'h120); lat = 2; tick();
    half(); tick();
    BranchTaken = 1'b1; BranchTarget = 32'h200;
    half(); tick(); clear_redirect();
    lat = 1;
    half(); check("brsame_addr", ImemAddr, 32'h200); check("brsame_valid", InstrValid, 32'd0); tick();
    half(); tick();

    JREn = 1'b1; JRTarget = 32'hFFFF_FFFC;
    half(); tick(); clear_redirect();
    half(); check("wrap_req_addr", ImemAddr, 32'hFFFF_FFFC); tick();
    half(); tick();
    half(); check("wrap_pc4", PCPlus4, 32'h0); check("wrap_next_addr", ImemAddr, 32'h0); tick();

    for (int i = 0; i < 24; i++) begin
      Stall = stall_pat[i];
      lat = (i % 3) + 1;
      half(); tick();
    end
    Stall = 1'b0; lat = 1;
    JREn = 1'b1; JRTarget = 32'h0;
    half(); tick(); clear_redirect();

    for (int i = 0; i < 80 && found == 0; i++) begin
      half();
      if (ImemReq && ImemAddr == 32'h20) begin found = 1; lat = 2; end
      tick();
    end
    check("reach_0x20", found, 32'd1);

    Rst = 1'b0;
    half();
    check("midrst_req", ImemReq, 32'd0); check("midrst_valid", InstrValid, 32'd0);
    check("midrst_instr", Instruction, 32'h0); check("midrst_pc4", PCPlus4, 32'h0);
    tick();
    Rst = 1'b1; lat = 1;
    half(); check("postrst_req", ImemReq, 32'd1); check("postrst_addr", ImemAddr, 32'h0); tick();
    half(); check("late_ignored", InstrValid, 32'd0); tick();
    half();
    check("postrst_instr", Instruction, 32'hDEAD_BEEF); check("postrst_pc4", PCPlus4, 32'h4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
